// File: rtl/push_button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
// The FSM state encoding is also visible to any logic that wants to inspect it.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;

    // Width of a counter that must hold values 0..n. Never narrower than 1 bit.
    function automatic int unsigned cnt_width(input longint unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/double_ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The flops carry no reset so they never hold the pin value back after reset.
module double_ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/push_button_debouncer.sv
// Debounces a raw push-button pin into a clean level plus press, release and
// long-press pulses and a wrapping press counter.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// RELEASED    | button accepted as released, waiting for a pressed sample
// PRESS_CHK   | pressed samples seen, counting until the press is accepted
// PRESSED     | button accepted as pressed, waiting for a released sample
// RELEASE_CHK | released samples seen, counting until the release is accepted
module push_button_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_CLK_FREQ / 50,
    parameter int unsigned LONG_CYCLES   = DEF_CLK_FREQ,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_press,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned STAB_W = cnt_width(longint'(STABLE_CYCLES));
    localparam int unsigned HOLD_W = cnt_width(longint'(LONG_CYCLES));

    localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);
    localparam bit LONG_EN      = (LONG_CYCLES != 0);

    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'((STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_EN ? LONG_CYCLES - 1 : 0);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("push_button_debouncer: STABLE_CYCLES must be at least 1");
    end
    if (LONG_CYCLES == 1) begin : g_bad_long
        $error("push_button_debouncer: LONG_CYCLES must be 0 or at least 2");
    end

    logic              sync_q;
    logic              pressed_raw;
    btn_state_t        state;
    logic [STAB_W-1:0] stab_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    double_ff u_sync (
        .clk (clk),
        .d   (btn_in),
        .q   (sync_q)
    );

    assign pressed_raw = ACTIVE_LOW ? ~sync_q : sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            stab_cnt      <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            case (state)
                RELEASED: begin
                    if (pressed_raw) begin
                        if (SINGLE_CYCLE) begin
                            state       <= PRESSED;
                            stab_cnt    <= '0;
                            btn_level   <= 1'b1;
                            press_pulse <= 1'b1;
                            press_count <= press_count + COUNT_W'(1);
                        end else begin
                            state    <= PRESS_CHK;
                            stab_cnt <= STAB_ONE;
                        end
                    end
                end

                PRESS_CHK: begin
                    if (!pressed_raw) begin
                        state    <= RELEASED;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state       <= PRESSED;
                        stab_cnt    <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + COUNT_W'(1);
                    end else begin
                        stab_cnt <= stab_cnt + STAB_ONE;
                    end
                end

                PRESSED: begin
                    if (!pressed_raw) begin
                        if (SINGLE_CYCLE) begin
                            state         <= RELEASED;
                            stab_cnt      <= '0;
                            btn_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            state    <= RELEASE_CHK;
                            stab_cnt <= STAB_ONE;
                        end
                    end
                end

                RELEASE_CHK: begin
                    if (pressed_raw) begin
                        state    <= PRESSED;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state         <= RELEASED;
                        stab_cnt      <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_ONE;
                    end
                end

                default: begin
                    state    <= RELEASED;
                    stab_cnt <= '0;
                end
            endcase

            // Hold time is measured on the registered level, so the long-press
            // pulse can never land on the same cycle as press_pulse.
            if (!btn_level) begin
                hold_cnt <= '0;
            end else if (LONG_EN && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_FIRE) begin
                    long_press <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_push_button_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned LONG   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    int tests_run    = 0;
    int tests_failed = 0;

    push_button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .ACTIVE_LOW    (1'b1),
        .COUNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        btn_in = 1'b1;
        rst    = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Button held (pin low) through reset: reported STABLE edges after release of rst.
    task automatic test_reset;
        rst    = 1'b1;
        btn_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if ({btn_level, press_pulse, release_pulse, long_press, press_count} !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got lvl=%b pp=%b rp=%b lp=%b cnt=%0d, want all 0",
                         i, btn_level, press_pulse, release_pulse, long_press, press_count);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests_run++;
            if (btn_level !== (i >= 4) || press_pulse !== (i == 4)) begin
                tests_failed++;
                $display("FAIL reset_held_press edge %0d: got lvl=%b pp=%b, want lvl=%b pp=%b",
                         i, btn_level, press_pulse, (i >= 4), (i == 4));
            end
        end
        tests_run++;
        if (press_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL reset_held_count: got %0d, want 1", press_count);
        end
    endtask

    task automatic test_clean_press;
        do_reset();
        btn_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            tests_run++;
            if (btn_level !== (i >= 6) || press_pulse !== (i == 6)) begin
                tests_failed++;
                $display("FAIL clean_press edge %0d: got lvl=%b pp=%b, want lvl=%b pp=%b",
                         i, btn_level, press_pulse, (i >= 6), (i == 6));
            end
        end
        tests_run++;
        if (press_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL clean_press_count: got %0d, want 1", press_count);
        end
    endtask

    task automatic test_bounce;
        logic pattern [14];
        do_reset();
        for (int i = 0; i < 14; i++) pattern[i] = 1'b1;
        for (int i = 0; i < 3; i++) pattern[i] = 1'b0;
        for (int i = 4; i < 7; i++) pattern[i] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            btn_in = pattern[i];
            tick();
            tests_run++;
            if (btn_level !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0 || press_count !== 8'd0) begin
                tests_failed++;
                $display("FAIL bounce step %0d: got lvl=%b pp=%b rp=%b cnt=%0d, want 0 0 0 0",
                         i, btn_level, press_pulse, release_pulse, press_count);
            end
        end
    endtask

    task automatic test_long_press;
        int pulses;
        do_reset();
        btn_in = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        tests_run++;
        if (btn_level !== 1'b1 || press_pulse !== 1'b1 || long_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_rise: got lvl=%b pp=%b lp=%b, want 1 1 0", btn_level, press_pulse, long_press);
        end
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (long_press === 1'b1) pulses++;
            tests_run++;
            if (long_press !== (i == 10)) begin
                tests_failed++;
                $display("FAIL long_press cycle %0d after rise: got %b, want %b", i, long_press, (i == 10));
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL long_press_count: got %0d pulses, want 1", pulses);
        end
    endtask

    // Continues from the held press left by test_long_press.
    task automatic test_release;
        int rel;
        rel = 0;
        btn_in = 1'b1;
        tick();
        tick();
        btn_in = 1'b0;
        tick();
        tick();
        if (release_pulse === 1'b1) rel++;
        tests_run++;
        if (btn_level !== 1'b1 || long_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_bounce_level: got lvl=%b lp=%b, want 1 0", btn_level, long_press);
        end
        btn_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (release_pulse === 1'b1) rel++;
            tests_run++;
            if (btn_level !== (i < 6) || release_pulse !== (i == 6) || long_press !== 1'b0) begin
                tests_failed++;
                $display("FAIL release edge %0d: got lvl=%b rp=%b lp=%b, want lvl=%b rp=%b lp=0",
                         i, btn_level, release_pulse, long_press, (i < 6), (i == 6));
            end
        end
        tests_run++;
        if (rel != 1) begin
            tests_failed++;
            $display("FAIL release_count: got %0d release pulses, want 1", rel);
        end
    endtask

    task automatic test_wrap_and_reset;
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            btn_in = 1'b0;
            for (int i = 0; i < 6; i++) tick();
            btn_in = 1'b1;
            for (int i = 0; i < 6; i++) tick();
            if (n == 1 || n == 255 || n == 256) begin
                tests_run++;
                if (press_count !== 8'(n) || btn_level !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap after %0d presses: got cnt=%0d lvl=%b, want cnt=%0d lvl=0",
                             n, press_count, btn_level, 8'(n));
                end
            end
        end
        btn_in = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (btn_level !== 1'b1 || press_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL pre_mid_reset: got lvl=%b cnt=%0d, want 1 1", btn_level, press_count);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (btn_level !== 1'b0 || press_count !== 8'd0 || release_pulse !== 1'b0 || press_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got lvl=%b cnt=%0d rp=%b pp=%b, want 0 0 0 0",
                     btn_level, press_count, release_pulse, press_pulse);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests_run++;
            if (btn_level !== (i >= 4) || press_pulse !== (i == 4) || release_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_mid_reset edge %0d: got lvl=%b pp=%b rp=%b, want lvl=%b pp=%b rp=0",
                         i, btn_level, press_pulse, release_pulse, (i >= 4), (i == 4));
            end
        end
        tests_run++;
        if (press_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL post_mid_reset_count: got %0d, want 1", press_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
